// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the RV32M multiply/divide unit:
//   - md_state_e : FSM state encoding (IDLE, BUSY, DONE)
//   - funct3 encodings for the eight M-extension operations
//   - decode constants for the M-extension R-type group
//   - helpers that give the operand signedness of each funct3
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    localparam logic [6:0] M_FUNCT7     = 7'h01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    // op_a is treated as two's complement for these operations.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
    endfunction

    // op_b is treated as two's complement for these operations.
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit_if
// Signals between the EX stage / pipeline control and the multiply/divide unit.
//   Pipeline -> unit : flush, ex_alu_op, ex_funct7, ex_funct3, op_a, op_b
//   Unit -> pipeline : md_sel, md_stall, md_done, md_result
// Handshake: the request is the decoded ID/EX contents (ex_alu_op == R-type and
// ex_funct7 == M). The pipeline must hold them stable while md_stall is high;
// md_done marks the single cycle in which md_result belongs to that
// instruction and the instruction advances out of ID/EX at the end of it.
// Modports: master = pipeline side, slave = multiply/divide unit.
// -----------------------------------------------------------------------------
interface ex_muldiv_unit_if;
    logic        flush;
    logic [1:0]  ex_alu_op;
    logic [6:0]  ex_funct7;
    logic [2:0]  ex_funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        md_sel;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

    modport master (
        output flush, ex_alu_op, ex_funct7, ex_funct3, op_a, op_b,
        input  md_sel, md_stall, md_done, md_result
    );

    modport slave (
        input  flush, ex_alu_op, ex_funct7, ex_funct3, op_a, op_b,
        output md_sel, md_stall, md_done, md_result
    );
endinterface

// File: rtl/muldiv_seq_core.sv
// -----------------------------------------------------------------------------
// muldiv_seq_core
// Radix-2 step datapath for the iterative multiply/divide.
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   i_load       : latch operands (as magnitudes) and op flags, count := 31
//   i_step       : perform one step
//   i_funct3     : M operation select (sampled on i_load)
//   i_op_a/i_op_b: operands (sampled on i_load)
//   o_last       : the step performed this cycle is the final one
//   o_result     : sign-corrected result of the step being performed now;
//                  valid in the cycle where o_last && i_step
// Accumulator layout: r_acc[63:32] = partial product high / remainder,
// r_acc[31:0] = multiplier shifting out / dividend shifting into quotient.
// -----------------------------------------------------------------------------
module muldiv_seq_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic        o_last,
    output logic [31:0] o_result
);

    logic [63:0] r_acc;
    logic [31:0] r_b;      // divisor magnitude or multiplicand magnitude
    logic [4:0]  r_cnt;
    logic        r_neg;    // final result must be negated
    logic        r_is_div;
    logic        r_hi;     // select REM (divide) or product[63:32] (multiply)

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_ld_div;

    assign w_neg_a  = f3_a_signed(i_funct3) & i_op_a[31];
    assign w_neg_b  = f3_b_signed(i_funct3) & i_op_b[31];
    assign w_mag_a  = w_neg_a ? (~i_op_a + 32'd1) : i_op_a;
    assign w_mag_b  = w_neg_b ? (~i_op_b + 32'd1) : i_op_b;
    assign w_ld_div = i_funct3[2];

    // Restoring divide step. The remainder is always below the divisor, so
    // after the shift it fits in 33 bits.
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [63:0] w_div_next;

    assign w_rem_sh   = r_acc[63:31];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_div_next = {(w_ge ? w_diff[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_ge};

    // Shift-add multiply step: add the multiplicand into the high half when
    // the current multiplier bit is set, then shift the whole accumulator
    // right keeping the carry.
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;

    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_sum, r_acc[31:1]};

    logic [63:0] w_acc_next;
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // Sign fix-up on the value produced by this step.
    logic [63:0] w_prod_fix;
    logic [31:0] w_div_raw;
    logic [31:0] w_div_fix;

    assign w_prod_fix = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;
    assign w_div_raw  = r_hi ? w_acc_next[63:32] : w_acc_next[31:0];
    assign w_div_fix  = r_neg ? (~w_div_raw + 32'd1) : w_div_raw;

    assign o_result = r_is_div ? w_div_fix
                               : (r_hi ? w_prod_fix[63:32] : w_prod_fix[31:0]);
    assign o_last   = (r_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {32'd0, (w_ld_div ? w_mag_a : w_mag_b)};
            r_b      <= w_ld_div ? w_mag_b : w_mag_a;
            r_cnt    <= 5'd31;
            r_is_div <= w_ld_div;
            // Remainder follows the dividend; quotient/product follow the
            // sign difference of the operands.
            r_neg    <= (w_ld_div && i_funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
            r_hi     <= w_ld_div ? i_funct3[1] : (i_funct3 != MUL);
        end else if (i_step) begin
            r_acc <= w_acc_next;
            if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
// RV32M multiply/divide unit in the execute stage. Decodes M-extension R-type
// instructions from ID/EX, stalls the front of the pipeline while computing,
// and presents a registered result in the completion cycle.
// Ports:
//   clk          : clock
//   rstn         : synchronous active-low reset
//   md           : ex_muldiv_unit_if.slave (request decode, operands, flush,
//                  md_sel/md_stall/md_done/md_result)
//   o_dbg_state  : current FSM state
// Build option:
//   MULDIV_FAST_MUL_EN - multiplies use a single-cycle 33x33 signed multiplier
//                        and complete like the divide special cases (one stall
//                        cycle). Undefined: multiplies run the 32-step path.
// -----------------------------------------------------------------------------
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    ex_muldiv_unit_if.slave   md,
    output md_state_e         o_dbg_state
);

    md_state_e   r_state;
    logic        r_md_done;
    logic [31:0] r_md_result;

    logic        w_md_req;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic        w_fast;
    logic [31:0] w_fast_res;
    logic        w_core_load;
    logic        w_core_step;
    logic        w_core_last;
    logic [31:0] w_core_result;

    assign w_md_req = (md.ex_alu_op == ALU_OP_RTYPE) && (md.ex_funct7 == M_FUNCT7);
    assign w_is_div = md.ex_funct3[2];

    // Divide corners that the iterative path would get wrong or that have an
    // architecturally fixed answer: resolved in one cycle.
    assign w_div_zero = w_is_div && (md.op_b == 32'd0);
    assign w_ovf      = ((md.ex_funct3 == DIV) || (md.ex_funct3 == REM)) &&
                        (md.op_a == 32'h8000_0000) && (md.op_b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero) begin
            w_special_res = md.ex_funct3[1] ? md.op_a : 32'hFFFF_FFFF;
        end else if (w_ovf) begin
            w_special_res = md.ex_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // 33-bit operands carry the per-op signedness; sign-extending both to 64
    // bits and keeping the low 64 product bits gives the exact signed product.
    logic [32:0] w_fa;
    logic [32:0] w_fb;
    logic [63:0] w_fprod;

    assign w_fa       = {f3_a_signed(md.ex_funct3) & md.op_a[31], md.op_a};
    assign w_fb       = {f3_b_signed(md.ex_funct3) & md.op_b[31], md.op_b};
    assign w_fprod    = {{31{w_fa[32]}}, w_fa} * {{31{w_fb[32]}}, w_fb};
    assign w_fast     = !w_is_div;
    assign w_fast_res = (md.ex_funct3 == MUL) ? w_fprod[31:0] : w_fprod[63:32];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = 32'd0;
`endif

    // The core's load is the operand latch: forwarding sources may change
    // while the pipeline is stalled.
    assign w_core_load = (r_state == IDLE) && w_md_req && !md.flush &&
                         !w_special && !w_fast;
    assign w_core_step = (r_state == BUSY) && !md.flush;

    muldiv_seq_core u_core (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_core_load),
        .i_step   (w_core_step),
        .i_funct3 (md.ex_funct3),
        .i_op_a   (md.op_a),
        .i_op_b   (md.op_b),
        .o_last   (w_core_last),
        .o_result (w_core_result)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_md_done   <= 1'b0;
            r_md_result <= 32'd0;
        end else begin
            r_md_done <= 1'b0;
            if (md.flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_md_req) begin
                            if (w_special) begin
                                r_md_result <= w_special_res;
                                r_md_done   <= 1'b1;
                                r_state     <= DONE;
                            end else if (w_fast) begin
                                r_md_result <= w_fast_res;
                                r_md_done   <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        if (w_core_last) begin
                            r_md_result <= w_core_result;
                            r_md_done   <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                    // The instruction leaves ID/EX this cycle; returning to
                    // IDLE unconditionally keeps it from being restarted.
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign md.md_sel    = w_md_req;
    assign md.md_stall  = ((r_state == IDLE) && w_md_req) || (r_state == BUSY);
    assign md.md_done   = r_md_done;
    assign md.md_result = r_md_result;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Table-driven bench for ex_muldiv_unit: a vector table of operations with
// hand-computed results and stall latencies, followed by hand-written
// sequences for flush, mid-operation reset and back-to-back operations.
// -----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if md_if ();
    md_state_e        dbg_state;

    ex_muldiv_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .md          (md_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fails  = 0;
    int          done_pulses = 0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (md_if.md_done === 1'b1) done_pulses++;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        md_if.flush     = 1'b0;
        md_if.ex_alu_op = 2'b00;
        md_if.ex_funct7 = 7'h00;
        md_if.ex_funct3 = 3'd0;
        md_if.op_a      = 32'd0;
        md_if.op_b      = 32'd0;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        md_if.flush     = 1'b0;
        md_if.ex_alu_op = 2'b10;
        md_if.ex_funct7 = 7'h01;
        md_if.ex_funct3 = f3;
        md_if.op_a      = a;
        md_if.op_b      = b;
    endtask

    // Called just after a rising edge. Presents the instruction, counts stall
    // cycles until md_done, checks result and latency, and returns just after
    // the edge that ends the done cycle with the instruction still driven.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int stalls;
        bit got;
        stalls = 0;
        got = 1'b0;
        drive_op(f3, a, b);
        exp_q.push_back(exp);
        @(negedge clk);
        check32({name, " sel"}, {31'd0, md_if.md_sel}, 32'd1);
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (md_if.md_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (md_if.md_stall === 1'b1) stalls++;
            @(posedge clk);
            #1;
        end
        if (got) begin
            check32({name, " result"}, md_if.md_result, exp_q.pop_front());
            check32({name, " stall cycles"}, stalls, lat);
            check32({name, " stall at done"}, {31'd0, md_if.md_stall}, 32'd0);
        end else begin
            n_checks++;
            n_fails++;
            $display("FAIL %s timeout: md_done not seen within 100 cycles", name);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[22];

    initial begin
        int p0;

        vecs[0]  = '{"DIVU 100/7",          DIVU,   32'd100,        32'd7,          32'd14,         DIV_LAT};
        vecs[1]  = '{"REMU 100/7",          REMU,   32'd100,        32'd7,          32'd2,          DIV_LAT};
        vecs[2]  = '{"DIV -7/2",            DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DIV_LAT};
        vecs[3]  = '{"REM -7/2",            REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DIV_LAT};
        vecs[4]  = '{"DIV 7/-2",            DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  DIV_LAT};
        vecs[5]  = '{"REM 7/-2",            REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          DIV_LAT};
        vecs[6]  = '{"DIVU max/1",          DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  DIV_LAT};
        vecs[7]  = '{"DIV 5/0",             DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  SPC_LAT};
        vecs[8]  = '{"REM 5/0",             REM,    32'd5,          32'd0,          32'd5,          SPC_LAT};
        vecs[9]  = '{"DIVU 5/0",            DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  SPC_LAT};
        vecs[10] = '{"REMU 5/0",            REMU,   32'd5,          32'd0,          32'd5,          SPC_LAT};
        vecs[11] = '{"DIV ovf",             DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPC_LAT};
        vecs[12] = '{"REM ovf",             REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPC_LAT};
        vecs[13] = '{"MULH min*min",        MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT};
        vecs[14] = '{"MULHU max*2",         MULHU,  32'hFFFF_FFFF,  32'd2,          32'd1,          MUL_LAT};
        vecs[15] = '{"MUL 3*-4",            MUL,    32'd3,          32'hFFFF_FFFC,  32'hFFFF_FFF4,  MUL_LAT};
        vecs[16] = '{"MULHSU -1*2",         MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT};
        vecs[17] = '{"MULHU max*max",       MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT};
        vecs[18] = '{"MULH -1*-1",          MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          MUL_LAT};
        vecs[19] = '{"REMU 2^31/3",         REMU,   32'h8000_0000,  32'd3,          32'd2,          DIV_LAT};
        vecs[20] = '{"DIV min/2",           DIV,    32'h8000_0000,  32'd2,          32'hC000_0000,  DIV_LAT};
        vecs[21] = '{"MULHSU 2*max",        MULHSU, 32'd2,          32'hFFFF_FFFF,  32'd1,          MUL_LAT};

        // ---------------- reset state ----------------
        drive_idle();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset md_stall", {31'd0, md_if.md_stall}, 32'd0);
        check32("reset md_done", {31'd0, md_if.md_done}, 32'd0);
        check32("reset md_result", md_if.md_result, 32'd0);
        check32("reset state", {30'd0, dbg_state}, {30'd0, IDLE});
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            drive_idle();
            @(posedge clk);
            #1;
        end

        // ---------------- flush in BUSY cycle 10 ----------------
        drive_op(DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check32("flush pre state", {30'd0, dbg_state}, {30'd0, BUSY});
        md_if.flush = 1'b1;
        p0 = done_pulses;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check32("flush state", {30'd0, dbg_state}, {30'd0, IDLE});
        check32("flush md_stall", {31'd0, md_if.md_stall}, 32'd0);
        check32("flush md_done", {31'd0, md_if.md_done}, 32'd0);
        repeat (40) @(negedge clk);
        check32("flush no done pulse", done_pulses - p0, 32'd0);
        @(posedge clk);
        #1;
        run_op("DIVU 9/3 after flush", DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);
        drive_idle();
        @(posedge clk);
        #1;

        // ---------------- reset mid-BUSY ----------------
        drive_op(DIVU, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check32("midreset md_stall", {31'd0, md_if.md_stall}, 32'd0);
        check32("midreset md_done", {31'd0, md_if.md_done}, 32'd0);
        check32("midreset md_result", md_if.md_result, 32'd0);
        check32("midreset md_sel", {31'd0, md_if.md_sel}, 32'd0);
        check32("midreset state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- back-to-back ----------------
        p0 = done_pulses;
        run_op("b2b DIVU 1000/10", DIVU, 32'd1000, 32'd10, 32'd100, DIV_LAT);
        run_op("b2b DIVU 77/7", DIVU, 32'd77, 32'd7, 32'd11, DIV_LAT);
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("b2b done pulses", done_pulses - p0, 32'd2);
        check32("b2b result hold", md_if.md_result, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
